pre_if_pc_gen: RTL
==================

PRE_IF_PC_GEN -- requirements
Module: pre_if_pc_gen

Interface
REQ-001 SHALL have parameters: RESET_PC, default 32'hBFC0_0000, boot fetch address; INDEX_WIDTH, default 8, cache set index bits; OFFSET_WIDTH, default 4, line byte-offset bits.
REQ-002 SHALL have ports: clk in 1, clock; resetn in 1, reset, synchronous, active-low.
REQ-003 SHALL have ports: icache_busy_i in 1, ICache miss/uncached wait; id_stall_i in 1, downstream stall.
REQ-004 SHALL have ports: exc_valid_i in 1, exception/ERET redirect; exc_pc_i in 32, its target.
REQ-005 SHALL have ports: br_valid_i in 1, taken branch/jump redirect; br_target_i in 32, its target.
REQ-006 SHALL have ports: req_valid_o out 1, fetch request valid; req_tag_o out 32-INDEX_WIDTH-OFFSET_WIDTH, physical tag; req_index_o out INDEX_WIDTH; req_offset_o out OFFSET_WIDTH.
REQ-007 SHALL have ports: req_iscache_o out 1, cacheable; req_stall_o out 1, stall to ICache; pc_o out 32, virtual PC of request; pc_adel_o out 1, misaligned fetch flag.

Function
REQ-008 stall SHALL be icache_busy_i | id_stall_i; req_stall_o SHALL equal stall combinationally.
REQ-009 PC register SHALL hold its value in any cycle with stall=1.
REQ-010 With stall=0, next PC priority SHALL be: exc_valid_i -> exc_pc_i; pending exception -> its target; pending branch -> its target; br_valid_i -> br_target_i; else pc+4, wrapping 32'hFFFF_FFFC -> 0.
REQ-011 Redirect FSM states SHALL be RUN, HOLD_BR, HOLD_EXC, with one 32-bit pending-target register.
REQ-012 RUN: exc_valid_i with stall=1 -> HOLD_EXC, latch exc_pc_i; else br_valid_i with stall=1 -> HOLD_BR, latch br_target_i; redirect with stall=0 applied directly, stay RUN.
REQ-013 HOLD_BR: exc_valid_i SHALL overwrite target, go HOLD_EXC; br_valid_i SHALL overwrite target; first stall=0 cycle loads PC from pending (or exc_pc_i if exc_valid_i), returns RUN.
REQ-014 HOLD_EXC: br_valid_i SHALL be ignored; exc_valid_i SHALL overwrite target; first stall=0 cycle loads PC, returns RUN.
REQ-015 Address map from pc_o: 0x8000_0000-0x9FFF_FFFF cached, phys=pc&0x1FFF_FFFF; 0xA000_0000-0xBFFF_FFFF uncached, phys=pc&0x1FFF_FFFF; all others cached, phys=pc.
REQ-016 req_tag_o/req_index_o/req_offset_o SHALL be slices of the physical address, combinational from the PC register.
REQ-017 pc_adel_o SHALL be |pc[1:0]; req_valid_o SHALL be valid_q & ~pc_adel_o.
REQ-018 valid_q SHALL be 0 in reset and 1 from the first cycle after resetn deasserts.
REQ-019 Request latency: a PC loaded at edge N SHALL appear on request outputs in cycle N, zero added latency.
REQ-020 exc_valid_i and br_valid_i asserted together SHALL resolve to the exception target.

Reset
REQ-021 While resetn=0 at a clk edge: PC=RESET_PC, FSM=RUN, pending target=0, valid_q=0.
REQ-022 During and after reset, outputs SHALL follow the rules above: req_valid_o=0, pc_o=RESET_PC, req_iscache_o=0, pc_adel_o=0, req_stall_o=icache_busy_i|id_stall_i.
REQ-023 Reset mid-stall or mid-HOLD SHALL discard any pending redirect.

Structure
REQ-024 RESET_PC, segment boundaries and mask SHALL live in CPU_Defines; INDEX/OFFSET widths SHALL come from Cache_Defines.
REQ-025 Address translation SHALL be one combinational sub-module, pre_if_addr_map (vaddr in, paddr and iscache out).

Verification
REQ-026 Reset release, no stall -> pc_o 0xBFC00000, 0xBFC00004, 0xBFC00008; req_iscache_o=0; tag=0x1FC00, index=0x00, offset=0x0.
REQ-027 br_valid_i target 0x80001230 with stall=0 -> next cycle pc_o=0x80001230, iscache=1, index=0x23, offset=0x0.
REQ-028 icache_busy_i=1 for 5 cycles, br_valid_i target 0x80000100 in cycle 2 -> PC held; first unstalled edge pc_o=0x80000100.
REQ-029 In HOLD_BR, exc_valid_i 0xBFC00380 -> HOLD_EXC; later br_valid_i ignored; release -> pc_o=0xBFC00380.
REQ-030 exc_valid_i target 0x80000002 -> pc_adel_o=1, req_valid_o=0; next br/exc redirect clears.
REQ-031 PC 0xFFFFFFFC, no redirect, stall=0 -> pc_o wraps to 0x00000000, iscache=1, phys=pc.

Source files
------------

// File: rtl/pre_if_pc_gen_pkg.sv
// rtl/pre_if_pc_gen_pkg.sv - CPU/cache constants and pre-IF redirect FSM types
//
// CPU_Defines        : boot PC, kseg0/kseg1/kseg2 bases, physical mask
// Cache_Defines      : ICache index / offset widths
// pre_if_pc_gen_pkg  : redirect FSM state encoding, sequential PC helper

package CPU_Defines;
  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;
  localparam logic [31:0] PHYS_MASK  = 32'h1FFF_FFFF;
endpackage

package Cache_Defines;
  localparam int INDEX_WIDTH  = 8;
  localparam int OFFSET_WIDTH = 4;
endpackage

package pre_if_pc_gen_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD_BR  = 2'd1,
    HOLD_EXC = 2'd2
  } redirect_state_e;

  // Sequential fetch; 32-bit add wraps 0xFFFF_FFFC to 0 on its own.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/pre_if_pc_gen_addr_map.sv
// rtl/pre_if_pc_gen_addr_map.sv - fixed-segment virtual-to-physical translation
//
// Ports:
//   vaddr_i   in  32  virtual fetch address
//   paddr_o   out 32  physical address
//   iscache_o out 1   1 = cacheable access

module pre_if_addr_map
  import CPU_Defines::*;
(
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o,
  output logic        iscache_o
);

  logic in_kseg0;
  logic in_kseg1;

  assign in_kseg0 = (vaddr_i >= KSEG0_BASE) && (vaddr_i < KSEG1_BASE);
  assign in_kseg1 = (vaddr_i >= KSEG1_BASE) && (vaddr_i < KSEG2_BASE);

  // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else
  // passes straight through and is treated as cacheable.
  assign paddr_o   = (in_kseg0 || in_kseg1) ? (vaddr_i & PHYS_MASK) : vaddr_i;
  assign iscache_o = ~in_kseg1;

endmodule

// File: rtl/pre_if_pc_gen.sv
// rtl/pre_if_pc_gen.sv - pre-IF stage PC generator with stalled-redirect capture
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   icache_busy_i, id_stall_i stall sources
//   exc_valid_i, exc_pc_i    exception / ERET redirect
//   br_valid_i, br_target_i  taken branch / jump redirect
//   req_valid_o              fetch request valid
//   req_tag_o/index_o/offset_o physical address slices for the ICache
//   req_iscache_o            cacheable fetch
//   req_stall_o              stall forwarded to the ICache
//   pc_o                     virtual PC of the request
//   pc_adel_o                misaligned fetch address

module pre_if_pc_gen
  import CPU_Defines::*;
  import Cache_Defines::*;
  import pre_if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = CPU_Defines::RESET_PC,
  parameter int          INDEX_WIDTH  = Cache_Defines::INDEX_WIDTH,
  parameter int          OFFSET_WIDTH = Cache_Defines::OFFSET_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 icache_busy_i,
  input  logic                                 id_stall_i,
  input  logic                                 exc_valid_i,
  input  logic [31:0]                          exc_pc_i,
  input  logic                                 br_valid_i,
  input  logic [31:0]                          br_target_i,
  output logic                                 req_valid_o,
  output logic [31-INDEX_WIDTH-OFFSET_WIDTH:0] req_tag_o,
  output logic [INDEX_WIDTH-1:0]               req_index_o,
  output logic [OFFSET_WIDTH-1:0]              req_offset_o,
  output logic                                 req_iscache_o,
  output logic                                 req_stall_o,
  output logic [31:0]                          pc_o,
  output logic                                 pc_adel_o
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  logic            stall;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     pend_q, pend_d;
  redirect_state_e state_q, state_d;
  logic            valid_q;
  logic [31:0]     paddr;

  assign stall       = icache_busy_i | id_stall_i;
  assign req_stall_o = stall;

  // A redirect that arrives while stalled is parked in pend_q. An exception
  // always wins over a branch; once an exception is parked, later branches
  // belong to squashed instructions and are dropped.
  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (stall) begin
          if (exc_valid_i) begin
            pend_d  = exc_pc_i;
            state_d = HOLD_EXC;
          end else if (br_valid_i) begin
            pend_d  = br_target_i;
            state_d = HOLD_BR;
          end
        end else if (exc_valid_i) begin
          pc_d = exc_pc_i;
        end else if (br_valid_i) begin
          pc_d = br_target_i;
        end else begin
          pc_d = next_seq_pc(pc_q);
        end
      end
      HOLD_BR: begin
        if (stall) begin
          if (exc_valid_i) begin
            pend_d  = exc_pc_i;
            state_d = HOLD_EXC;
          end else if (br_valid_i) begin
            pend_d = br_target_i;
          end
        end else begin
          pc_d    = exc_valid_i ? exc_pc_i : pend_q;
          state_d = RUN;
        end
      end
      HOLD_EXC: begin
        if (stall) begin
          if (exc_valid_i) begin
            pend_d = exc_pc_i;
          end
        end else begin
          pc_d    = exc_valid_i ? exc_pc_i : pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      state_q <= RUN;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      valid_q <= 1'b1;
    end
  end

  pre_if_addr_map u_addr_map (
    .vaddr_i   (pc_q),
    .paddr_o   (paddr),
    .iscache_o (req_iscache_o)
  );

  // Request fields come straight off the PC register: no added latency.
  assign pc_o         = pc_q;
  assign pc_adel_o    = |pc_q[1:0];
  assign req_valid_o  = valid_q & ~pc_adel_o;
  assign req_tag_o    = paddr[31 -: TAG_WIDTH];
  assign req_index_o  = paddr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_offset_o = paddr[OFFSET_WIDTH-1:0];

endmodule
